// File: rtl/arb_requester.sv
// Requester-side agent for the 3-source priority arbiter: local job FIFO,
// aged request priority, and burst ownership tracking after each grant.
module arb_requester #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned AGE_PERIOD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [2:0] push_prio,
    input  logic [3:0] push_len,
    input  logic [1:0] push_tag,
    input  logic       gnt,
    output logic       req,
    output logic [2:0] prio,
    output logic       own,
    output logic [1:0] cur_tag,
    output logic       full,
    output logic       empty,
    output logic       overflow,
    output logic       spurious
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned AW = (AGE_PERIOD > 1) ? $clog2(AGE_PERIOD) : 1;

    typedef struct packed {
        logic [2:0] prio;
        logic [3:0] len;
        logic [1:0] tag;
    } job_t;

    typedef enum logic [1:0] {IDLE, REQ, BURST} state_t;

    job_t          mem [DEPTH];
    job_t          head;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    state_t        state, state_nxt;
    logic [AW-1:0] age, age_nxt;
    logic [3:0]    bcnt, bcnt_nxt;
    logic [2:0]    eff_prio, eff_prio_nxt;
    logic [1:0]    tag_q, tag_nxt;
    logic          pop, push_ok;

    assign head    = mem[rd_ptr];
    assign pop     = (state == REQ) && gnt;
    assign push_ok = push && (!full || pop);

    // Outputs decode registered state only; no path from gnt or push.
    assign req     = (state == REQ);
    assign own     = (state == BURST);
    assign cur_tag = own ? tag_q : 2'd0;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign prio    = (state == REQ) ? eff_prio : (empty ? 3'd0 : head.prio);

    // Next-state: aging in REQ, grant wins over an aging step.
    always_comb begin
        state_nxt    = state;
        age_nxt      = age;
        bcnt_nxt     = bcnt;
        eff_prio_nxt = eff_prio;
        tag_nxt      = tag_q;
        case (state)
            IDLE: begin
                age_nxt = '0;
                if (count != '0) begin
                    eff_prio_nxt = head.prio;
                    state_nxt    = REQ;
                end
            end
            REQ: begin
                if (gnt) begin
                    state_nxt = BURST;
                    bcnt_nxt  = head.len;
                    tag_nxt   = head.tag;
                    age_nxt   = '0;
                end else if (age == AW'(AGE_PERIOD - 1)) begin
                    age_nxt = '0;
                    if (eff_prio != 3'd7) eff_prio_nxt = eff_prio + 3'd1;
                end else begin
                    age_nxt = age + AW'(1);
                end
            end
            BURST: begin
                // Return via IDLE: leaves one quiet cycle before the next request.
                if (bcnt == 4'd0) state_nxt = IDLE;
                else              bcnt_nxt  = bcnt - 4'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            age      <= '0;
            bcnt     <= '0;
            eff_prio <= '0;
            tag_q    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            spurious <= 1'b0;
        end else begin
            state    <= state_nxt;
            age      <= age_nxt;
            bcnt     <= bcnt_nxt;
            eff_prio <= eff_prio_nxt;
            tag_q    <= tag_nxt;
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            overflow <= overflow | (push & ~push_ok);
            spurious <= spurious | (gnt & (state != REQ));
        end
    end

    // Job storage is not reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) mem[wr_ptr] <= '{prio: push_prio, len: push_len, tag: push_tag};
    end

endmodule

// File: tb/tb_arb_requester.sv
// Directed bench for arb_requester: single job, aging, fill/overflow,
// back-to-back bursts across pointer wrap, spurious grants, reset mid-burst.
module tb_arb_requester;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       push = 1'b0;
    logic [2:0] push_prio = '0;
    logic [3:0] push_len = '0;
    logic [1:0] push_tag = '0;
    logic       gnt = 1'b0;
    logic       req, own, full, empty, overflow, spurious;
    logic [2:0] prio;
    logic [1:0] cur_tag;

    int n_checks = 0;
    int n_fail   = 0;

    arb_requester #(.DEPTH(4), .AGE_PERIOD(8)) dut (
        .clk(clk), .rst(rst), .push(push), .push_prio(push_prio),
        .push_len(push_len), .push_tag(push_tag), .gnt(gnt),
        .req(req), .prio(prio), .own(own), .cur_tag(cur_tag),
        .full(full), .empty(empty), .overflow(overflow), .spurious(spurious)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_push(input logic [2:0] p, input logic [3:0] l, input logic [1:0] t);
        push = 1'b1; push_prio = p; push_len = l; push_tag = t;
    endtask

    // Serve one len=0 job from REQ: grant, 1-cycle burst, quiet cycle, next req.
    task automatic serve(input logic [1:0] exp_tag, input logic [2:0] exp_prio, input logic more);
        chk("serve_req", 32'(req), 1);
        chk("serve_prio", 32'(prio), 32'(exp_prio));
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        chk("serve_own", 32'(own), 1);
        chk("serve_tag", 32'(cur_tag), 32'(exp_tag));
        chk("serve_req_low", 32'(req), 0);
        step();
        chk("serve_gap_own", 32'(own), 0);
        chk("serve_gap_req", 32'(req), 0);
        step();
        chk("serve_rerise", 32'(req), 32'(more));
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_req"}, 32'(req), 0);
        chk({tag, "_prio"}, 32'(prio), 0);
        chk({tag, "_own"}, 32'(own), 0);
        chk({tag, "_cur_tag"}, 32'(cur_tag), 0);
        chk({tag, "_full"}, 32'(full), 0);
        chk({tag, "_empty"}, 32'(empty), 1);
        chk({tag, "_overflow"}, 32'(overflow), 0);
        chk({tag, "_spurious"}, 32'(spurious), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset
        step(); step();
        rst = 1'b0;
        check_reset_state("rst");

        // Single job: prio 2, len 3, tag 1
        do_push(3'd2, 4'd3, 2'd1);
        step();
        push = 1'b0;
        chk("single_empty", 32'(empty), 0);
        chk("single_req_n", 32'(req), 0);
        chk("single_prio_idle", 32'(prio), 2);
        step();
        chk("single_req_n1", 32'(req), 1);
        chk("single_prio_req", 32'(prio), 2);
        step();
        chk("single_req_n2", 32'(req), 1);
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        chk("single_own0", 32'(own), 1);
        chk("single_tag0", 32'(cur_tag), 1);
        chk("single_req_gnt", 32'(req), 0);
        for (int i = 1; i < 4; i++) begin
            step();
            chk("single_own", 32'(own), 1);
            chk("single_tag", 32'(cur_tag), 1);
        end
        step();
        chk("single_own_end", 32'(own), 0);
        chk("single_tag_end", 32'(cur_tag), 0);
        chk("single_req_end", 32'(req), 0);
        chk("single_empty_end", 32'(empty), 1);

        // Aging with P=8
        do_push(3'd5, 4'd0, 2'd2);
        step();
        push = 1'b0;
        chk("age_prio_idle", 32'(prio), 5);
        step();
        chk("age_req", 32'(req), 1);
        chk("age_prio_start", 32'(prio), 5);
        do_push(3'd1, 4'd0, 2'd3);
        step();
        push = 1'b0;
        repeat (6) step();
        chk("age_prio_8cyc", 32'(prio), 5);
        step();
        chk("age_prio_step1", 32'(prio), 6);
        repeat (7) step();
        chk("age_prio_hold6", 32'(prio), 6);
        step();
        chk("age_prio_step2", 32'(prio), 7);
        repeat (100) step();
        chk("age_prio_sat", 32'(prio), 7);
        chk("age_req_hold", 32'(req), 1);
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        chk("age_gnt_own", 32'(own), 1);
        chk("age_gnt_tag", 32'(cur_tag), 2);
        chk("age_gnt_prio", 32'(prio), 1);
        step();
        chk("age_gap_prio", 32'(prio), 1);
        step();
        chk("age_next_req", 32'(req), 1);
        chk("age_next_prio", 32'(prio), 1);
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        chk("age_last_tag", 32'(cur_tag), 3);
        chk("age_last_empty", 32'(empty), 1);
        chk("age_last_prio", 32'(prio), 0);
        step();
        chk("age_done_own", 32'(own), 0);
        chk("age_done_spurious", 32'(spurious), 0);

        // Spurious grant mid-burst (len 2)
        do_push(3'd3, 4'd2, 2'd1);
        step();
        push = 1'b0;
        step();
        gnt = 1'b1;
        step();
        step();
        gnt = 1'b0;
        chk("spur_burst_flag", 32'(spurious), 1);
        chk("spur_burst_own", 32'(own), 1);
        chk("spur_burst_tag", 32'(cur_tag), 1);
        step();
        chk("spur_burst_len", 32'(own), 1);
        step();
        chk("spur_burst_end", 32'(own), 0);
        chk("spur_burst_req", 32'(req), 0);
        chk("spur_burst_empty", 32'(empty), 1);

        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("spur_cleared", 32'(spurious), 0);

        // Fill and overflow: tags 0..3 accepted, fifth dropped
        for (int i = 0; i < 4; i++) begin
            do_push(3'(i + 1), 4'd0, 2'(i));
            step();
            chk("fill_full", 32'(full), (i == 3) ? 1 : 0);
        end
        do_push(3'd7, 4'd0, 2'd2);
        step();
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_full", 32'(full), 1);
        chk("ovf_req", 32'(req), 1);
        do_push(3'd5, 4'd0, 2'd1);
        gnt = 1'b1;
        step();
        push = 1'b0;
        gnt = 1'b0;
        chk("pp_own", 32'(own), 1);
        chk("pp_tag", 32'(cur_tag), 0);
        chk("pp_full", 32'(full), 1);
        chk("pp_overflow", 32'(overflow), 1);
        step();
        chk("pp_gap_own", 32'(own), 0);
        step();
        serve(2'd1, 3'd2, 1'b1);
        serve(2'd2, 3'd3, 1'b1);
        serve(2'd3, 3'd4, 1'b1);
        serve(2'd1, 3'd5, 1'b0);
        chk("drain_empty", 32'(empty), 1);

        // Back-to-back across the wrapped pointers
        for (int i = 0; i < 3; i++) begin
            do_push(3'd0, 4'd0, 2'(i));
            step();
        end
        push = 1'b0;
        serve(2'd0, 3'd0, 1'b1);
        serve(2'd1, 3'd0, 1'b1);
        serve(2'd2, 3'd0, 1'b0);

        // Reset mid-burst at burst cycle 5 (len 15)
        do_push(3'd4, 4'd15, 2'd2);
        step();
        do_push(3'd1, 4'd0, 2'd1);
        step();
        push = 1'b0;
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        repeat (3) step();
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        chk("mid_own", 32'(own), 1);
        chk("mid_spurious", 32'(spurious), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_state("mid_rst");

        gnt = 1'b1;
        step();
        gnt = 1'b0;
        chk("idle_spur_flag", 32'(spurious), 1);
        chk("idle_spur_req", 32'(req), 0);
        chk("idle_spur_empty", 32'(empty), 1);

        do_push(3'd2, 4'd3, 2'd1);
        step();
        push = 1'b0;
        chk("post_rst_empty", 32'(empty), 0);
        chk("post_rst_req_n", 32'(req), 0);
        step();
        chk("post_rst_req", 32'(req), 1);
        chk("post_rst_prio", 32'(prio), 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
